// File: rtl/buart_pkg.sv
// buart_pkg: shared state encodings and frame constants for the buffered UART
package buart_pkg;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAITHI} rx_state_e;
    typedef enum logic [0:0] {TX_IDLE, TX_SEND} tx_state_e;
    localparam int FRAME_BITS = 10;
    localparam int GUARD_BITS = 15;
    localparam logic [3:0] FRAME_LAST = 4'(FRAME_BITS - 1);
    localparam logic [3:0] GUARD_LAST = 4'(GUARD_BITS - 1);
endpackage

// File: rtl/buart_sync_fifo.sv
// buart_sync_fifo: byte FIFO with extra pointer bit for full/empty; push accepted when full if popping
module buart_sync_fifo #(
    parameter int AW = 3
) (
    input  logic       clk,
    input  logic       resetq,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);
    logic [7:0]  mem [0:(1<<AW)-1];
    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic        do_push, do_pop;
    // status flags, accepted operations and next pointers
    always_comb begin
        empty   = wptr_q == rptr_q;
        full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wptr_d  = wptr_q + (AW+1)'(do_push);
        rptr_d  = rptr_q + (AW+1)'(do_pop);
        dout    = mem[rptr_q[AW-1:0]];
    end
    // storage is deliberately left unreset
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q[AW-1:0]] <= din;
    end
    // pointer registers
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end
endmodule

// File: rtl/buart_fifo.sv
// buart_fifo: 8N1 UART with RX/TX FIFOs, sticky error flags and a post-reset TX guard
module buart_fifo
    import buart_pkg::*;
#(
    parameter int DIVIDER = 104,
    parameter int RX_AW   = 3,
    parameter int TX_AW   = 3
) (
    input  logic       clk,
    input  logic       resetq,
    input  logic       rx,
    output logic       tx,
    input  logic       wr,
    input  logic [7:0] tx_data,
    output logic       tx_full,
    output logic       tx_idle,
    input  logic       rd,
    output logic [7:0] rx_data,
    output logic       valid,
    output logic       overrun,
    output logic       frame_err,
    input  logic       clr_err
);
    localparam int CW = $clog2(DIVIDER);
    localparam logic [CW-1:0] HALF = CW'(DIVIDER / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(DIVIDER - 1);

    logic [1:0]    sync_q, sync_d;
    logic          rxs;
    rx_state_e     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_sh_q, rx_sh_d;
    logic          overrun_q, overrun_d, frame_err_q, frame_err_d;
    logic          rx_push, set_fe, rx_full, rx_empty;

    tx_state_e     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]    tx_bit_q, tx_bit_d;
    logic [8:0]    tx_sh_q, tx_sh_d;
    logic          tx_q, tx_d, guard_q, guard_d;
    logic          load, tx_empty;
    logic [7:0]    tx_head;

    assign rxs       = sync_q[1];
    assign tx        = tx_q;
    assign valid     = !rx_empty;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

    buart_sync_fifo #(.AW(RX_AW)) u_rx_fifo (
        .clk(clk), .resetq(resetq), .push(rx_push), .din(rx_sh_q),
        .pop(rd), .dout(rx_data), .empty(rx_empty), .full(rx_full)
    );

    buart_sync_fifo #(.AW(TX_AW)) u_tx_fifo (
        .clk(clk), .resetq(resetq), .push(wr), .din(tx_data),
        .pop(load), .dout(tx_head), .empty(tx_empty), .full(tx_full)
    );

    // receiver: synchroniser, mid-bit sampling FSM and sticky error flags
    always_comb begin
        sync_d     = {sync_q[0], rx};
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CW'(1);
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_push    = 1'b0;
        set_fe     = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (!rxs) rx_state_d = RX_START;
            end
            RX_START: if (rx_cnt_q == HALF) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rxs ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt_q == LAST) begin
                rx_cnt_d = '0;
                rx_sh_d  = {rxs, rx_sh_q[7:1]};
                rx_bit_d = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            end
            RX_STOP: if (rx_cnt_q == LAST) begin
                rx_cnt_d   = '0;
                rx_push    = rxs;
                set_fe     = !rxs;
                rx_state_d = rxs ? RX_IDLE : RX_WAITHI;
            end
            RX_WAITHI: begin
                rx_cnt_d = '0;
                if (rxs) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
        overrun_d   = (rx_push && rx_full && !rd) ? 1'b1 : clr_err ? 1'b0 : overrun_q;
        frame_err_d = set_fe ? 1'b1 : clr_err ? 1'b0 : frame_err_q;
    end

    // transmitter: guard timing after reset, then back-to-back frames from the FIFO
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = (tx_cnt_q == LAST) ? '0 : tx_cnt_q + CW'(1);
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_d       = tx_q;
        guard_d    = guard_q;
        load       = 1'b0;
        if (tx_state_q == TX_IDLE) begin
            guard_d = guard_q || (tx_cnt_q == LAST && tx_bit_q == GUARD_LAST);
            if (!guard_q && tx_cnt_q == LAST) tx_bit_d = tx_bit_q + 4'd1;
            if (guard_q) tx_cnt_d = '0;
            load = guard_d && !tx_empty;
        end else if (tx_cnt_q == LAST) begin
            if (tx_bit_q == FRAME_LAST) begin
                load       = !tx_empty;
                tx_state_d = TX_IDLE;
                tx_d       = 1'b1;
            end else begin
                tx_d     = tx_sh_q[0];
                tx_sh_d  = {1'b1, tx_sh_q[8:1]};
                tx_bit_d = tx_bit_q + 4'd1;
            end
        end
        if (load) begin
            tx_state_d = TX_SEND;
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
            tx_sh_d    = {1'b1, tx_head};
            tx_d       = 1'b0;
        end
        tx_idle = tx_state_q == TX_IDLE && tx_empty && guard_q;
    end

    // state registers for both directions
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            sync_q      <= 2'b11;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_sh_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_sh_q     <= '1;
            tx_q        <= 1'b1;
            guard_q     <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_sh_q     <= rx_sh_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_sh_q     <= tx_sh_d;
            tx_q        <= tx_d;
            guard_q     <= guard_d;
        end
    end
endmodule

// File: tb/tb_buart_fifo.sv
// tb_buart_fifo: table-driven, directed and randomized checks of buart_fifo at DIVIDER=8
module tb_buart_fifo;
    logic       clk = 1'b0, resetq = 1'b0, rx = 1'b1, wr = 1'b0, rd = 1'b0, clr_err = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx, tx_full, tx_idle, valid, overrun, frame_err;
    logic [7:0] rx_data;
    int total = 0, bad = 0;

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_ferr;
    } rxv_t;
    rxv_t vec [6];

    logic [7:0] q[$];
    logic       ov_m;
    logic [19:0] bits;

    buart_fifo #(.DIVIDER(8), .RX_AW(3), .TX_AW(3)) dut (
        .clk(clk), .resetq(resetq), .rx(rx), .tx(tx), .wr(wr), .tx_data(tx_data),
        .tx_full(tx_full), .tx_idle(tx_idle), .rd(rd), .rx_data(rx_data),
        .valid(valid), .overrun(overrun), .frame_err(frame_err), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        tick(8);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic pop();
        rd = 1'b1;
        tick(1);
        rd = 1'b0;
    endtask

    task automatic clear();
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
    endtask

    initial begin
        vec[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0};
        vec[1] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1'b1};
        vec[2] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
        vec[3] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
        vec[4] = '{8'h81, 1'b0, 1'b0, 8'h00, 1'b1};
        vec[5] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 1'b0};
        bits = {1'b1, 8'hAA, 1'b0, 1'b1, 8'h55, 1'b0};

        tick(3);
        chk("rst_tx", tx, 1);
        chk("rst_tx_full", tx_full, 0);
        chk("rst_tx_idle", tx_idle, 0);
        chk("rst_valid", valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_frame_err", frame_err, 0);
        resetq = 1'b1;
        tick(2);

        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(20);
        chk("glitch_valid", valid, 0);
        chk("glitch_overrun", overrun, 0);
        chk("glitch_frame_err", frame_err, 0);

        for (int i = 0; i < 6; i++) begin
            send_frame(vec[i].d, vec[i].stop);
            rx = 1'b1;
            tick(4);
            chk($sformatf("vec%0d_valid", i), valid, vec[i].exp_valid);
            if (vec[i].exp_valid) chk($sformatf("vec%0d_data", i), rx_data, vec[i].exp_data);
            chk($sformatf("vec%0d_ferr", i), frame_err, vec[i].exp_ferr);
            pop();
            clear();
            chk($sformatf("vec%0d_valid_after_rd", i), valid, 0);
            chk($sformatf("vec%0d_ferr_after_clr", i), frame_err, 0);
        end

        send_frame(8'h3C, 1'b0);
        tick(40);
        chk("ferr_hold_flag", frame_err, 1);
        chk("ferr_hold_valid", valid, 0);
        rx = 1'b1;
        tick(90);
        chk("ferr_no_restart", valid, 0);
        clear();
        chk("ferr_cleared", frame_err, 0);
        send_frame(8'h11, 1'b1);
        tick(4);
        chk("ferr_recover_valid", valid, 1);
        chk("ferr_recover_data", rx_data, 8'h11);
        chk("ferr_recover_flag", frame_err, 0);
        pop();

        for (int i = 0; i < 9; i++) begin
            send_frame(8'(i), 1'b1);
            tick(2);
            if (i == 7) chk("ovr_not_yet", overrun, 0);
        end
        tick(2);
        chk("ovr_set", overrun, 1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ovr_data%0d", i), rx_data, 8'(i));
            pop();
        end
        chk("ovr_drained", valid, 0);
        clear();
        chk("ovr_cleared", overrun, 0);

        ov_m = 1'b0;
        for (int n = 0; n < 24; n++) begin
            logic [7:0] d;
            d = 8'($urandom);
            send_frame(d, 1'b1);
            tick(4);
            if (q.size() < 8) q.push_back(d);
            else ov_m = 1'b1;
            chk("rnd_valid", valid, q.size() != 0);
            if ($urandom_range(0, 2) == 0) begin
                for (int k = $urandom_range(1, 3); k > 0; k--) begin
                    if (q.size() != 0) chk("rnd_data", rx_data, q.pop_front());
                    pop();
                end
            end
        end
        chk("rnd_overrun", overrun, ov_m);
        while (q.size() != 0) begin
            chk("rnd_drain", rx_data, q.pop_front());
            pop();
        end
        chk("rnd_empty", valid, 0);
        clear();

        resetq = 1'b0;
        tick(2);
        resetq = 1'b1;
        for (int i = 0; i <= 280; i++) begin
            wr = i < 2;
            tx_data = (i == 0) ? 8'h55 : 8'hAA;
            chk($sformatf("tx_s%0d", i), tx, (i < 120 || i >= 280) ? 1'b1 : bits[(i - 120) / 8]);
            if (i == 0 || i == 279) chk($sformatf("tx_idle_s%0d", i), tx_idle, 0);
            if (i == 280) chk("tx_idle_end", tx_idle, 1);
            tick(1);
            wr = 1'b0;
        end

        send_frame(8'h77, 1'b1);
        tick(4);
        chk("mr_valid_pre", valid, 1);
        for (int k = 0; k < 9; k++) begin
            wr = 1'b1;
            tx_data = 8'h00;
            tick(1);
        end
        wr = 1'b0;
        chk("mr_full_pre", tx_full, 1);
        tick(10);
        chk("mr_tx_busy", tx, 0);
        #2 resetq = 1'b0;
        #1;
        chk("mr_tx", tx, 1);
        chk("mr_tx_full", tx_full, 0);
        chk("mr_valid", valid, 0);
        chk("mr_tx_idle", tx_idle, 0);
        tick(2);
        resetq = 1'b1;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/buart_fifo.md
BUART_FIFO -- requirements
Module: buart_fifo

Interface
REQ-001 SHALL have parameter DIVIDER, default 104, meaning clocks per bit period; legal range >= 4.
REQ-002 SHALL have parameter RX_AW, default 3, meaning log2 of RX FIFO depth (8 entries).
REQ-003 SHALL have parameter TX_AW, default 3, meaning log2 of TX FIFO depth (8 entries).
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port resetq  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port rx  in  1  serial input, asynchronous to clk.
REQ-007 SHALL have port tx  out  1  serial output, idle high.
REQ-008 SHALL have port wr  in  1  push tx_data into TX FIFO.
REQ-009 SHALL have port tx_data  in  8  byte to send.
REQ-010 SHALL have port tx_full  out  1  TX FIFO full.
REQ-011 SHALL have port tx_idle  out  1  TX FIFO empty, shifter idle, startup guard done.
REQ-012 SHALL have port rd  in  1  pop RX FIFO head.
REQ-013 SHALL have port rx_data  out  8  RX FIFO head, combinational.
REQ-014 SHALL have port valid  out  1  RX FIFO non-empty.
REQ-015 SHALL have port overrun  out  1  sticky: received byte dropped, RX FIFO full.
REQ-016 SHALL have port frame_err  out  1  sticky: stop bit sampled 0.
REQ-017 SHALL have port clr_err  in  1  clears overrun and frame_err.

Function
REQ-018 Bit period SHALL be exactly DIVIDER clocks; divider counters SHALL be $clog2(DIVIDER) bits wide and count 0..DIVIDER-1.
REQ-019 rx SHALL pass a 2-flop synchroniser (reset value 1) before any use.
REQ-020 RX FSM states: IDLE, START, DATA, STOP, WAITHI.
REQ-021 IDLE: synchronised rx=0 -> START, counter=0.
REQ-022 START: at count DIVIDER/2-1 sample; 1 -> IDLE (glitch, nothing recorded); 0 -> DATA, counter=0.
REQ-023 DATA: sample at count DIVIDER-1, LSB first; after 8th bit -> STOP.
REQ-024 STOP: sample at count DIVIDER-1; 1 -> push byte, -> IDLE; 0 -> set frame_err, discard byte, -> WAITHI.
REQ-025 WAITHI: remain until synchronised rx=1, then -> IDLE.
REQ-026 RX push SHALL be accepted when not full, or when full with rd in the same cycle; otherwise byte dropped and overrun set.
REQ-027 rd while valid=0 SHALL be ignored; pointers SHALL be RX_AW+1 bits, wrap modulo 2^(RX_AW+1).
REQ-028 overrun/frame_err SHALL clear on clr_err; simultaneous set and clr_err -> set wins.
REQ-029 wr while tx_full=1 SHALL be ignored, no flag; wr with simultaneous internal pop when full SHALL be accepted.
REQ-030 After reset tx SHALL hold 1 for 15 bit periods (guard) before first start bit.
REQ-031 TX idle with TX FIFO non-empty SHALL pop and drive start bit on next cycle; frame = start 0, 8 data LSB first, stop 1, each DIVIDER clocks.
REQ-032 Consecutive bytes SHALL be sent with no gap: next start bit immediately follows stop-bit period.

Reset
REQ-033 resetq low SHALL asynchronously force: tx=1, tx_full=0, tx_idle=0, valid=0, overrun=0, frame_err=0, both FSMs IDLE, pointers 0, counters 0, guard restarted.
REQ-034 FIFO storage SHALL NOT be reset; rx_data undefined while valid=0.
REQ-035 Reset mid-frame SHALL abort the frame; tx returns high within the reset assertion.

Structure
REQ-036 RX/TX state encodings, frame length (10) and guard length (15) SHALL live in package buart_pkg.
REQ-037 FIFOs SHALL be one sub-module, buart_sync_fifo (parameter AW, width 8), instantiated twice.

Verification (DIVIDER=8 unless stated)
REQ-038 Receive 0xA5, 8N1 -> valid rises after STOP sample, rx_data=0xA5; rd -> valid=0.
REQ-039 rx low pulse of 3 clocks -> no push, no flags, FSM back in IDLE.
REQ-040 Receive 9 bytes 0x00..0x08, no rd, RX_AW=3 -> 0x00..0x07 readable, 0x08 dropped, overrun=1; clr_err -> 0.
REQ-041 Frame 0x3C with stop bit 0, then line held low 40 clocks -> frame_err=1, no push, no restart until rx high.
REQ-042 After reset, wr 0x55 then 0xAA immediately -> tx high 120 clocks, then 20 contiguous bit periods 0,1010 1010,1,0,0101 0101,1; tx_idle rises after.
REQ-043 Assert resetq low mid-transmit -> tx=1 asynchronously, tx_full=0, valid=0.
